// File: rtl/a2d_scheduler.sv
// Round-robin scheduler sharing one SPI ADC master across battery, current, brake and torque.
// Each conversion is a command/read SPI pair; the read response carries the 12-bit result.
module a2d_scheduler #(
  parameter int FAST_SIM = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        snd,
  output logic [15:0] cmd,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        cnv_cmplt
);

  localparam int CW = (FAST_SIM != 0) ? 8 : 14;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    GAP,
    READ
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [CW-1:0] r_count;
  logic        r_pending;
  logic [1:0]  r_idx;
  logic        r_snd;
  logic [15:0] r_cmd;
  logic        r_cnv_cmplt;
  logic [11:0] r_result [4];

  logic        w_tick;
  logic        w_launch;
  logic        w_gap_snd;
  logic        w_latch;
  logic        w_done_ok;
  logic [2:0]  w_ch;

  assign w_tick = &r_count;
  // A done arriving while snd is still high belongs to nothing we launched yet.
  assign w_done_ok = done & ~r_snd;

  always_comb begin
    case (r_idx)
      2'd0:    w_ch = 3'd0;
      2'd1:    w_ch = 3'd1;
      2'd2:    w_ch = 3'd3;
      default: w_ch = 3'd4;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_gap_snd    = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_launch     = 1'b1;
          w_state_next = CMD;
        end
      end
      CMD: begin
        if (w_done_ok) begin
          w_state_next = GAP;
        end
      end
      GAP: begin
        w_gap_snd    = 1'b1;
        w_state_next = READ;
      end
      READ: begin
        if (w_done_ok) begin
          w_latch      = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_pending   <= 1'b0;
      r_idx       <= 2'd0;
      r_snd       <= 1'b0;
      r_cmd       <= 16'h0000;
      r_cnv_cmplt <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= r_count + 1'b1;
      // A tick in the launch cycle keeps the request alive; extra ticks saturate.
      r_pending   <= w_tick | (r_pending & ~w_launch);
      r_snd       <= w_launch | w_gap_snd;
      r_cnv_cmplt <= w_latch;
      if (w_launch) begin
        r_cmd <= {2'b00, w_ch, 11'h000};
      end
      if (w_latch) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_result
    always_ff @(posedge clk) begin
      if (rst) begin
        r_result[gi] <= 12'h000;
      end else if (w_latch && (r_idx == 2'(gi))) begin
        r_result[gi] <= resp[11:0];
      end
    end
  end

  assign snd       = r_snd;
  assign cmd       = r_cmd;
  assign cnv_cmplt = r_cnv_cmplt;
  assign batt      = r_result[0];
  assign curr      = r_result[1];
  assign brake     = r_result[2];
  assign torque    = r_result[3];

endmodule

// File: tb/tb_a2d_scheduler.sv
// Bench for a2d_scheduler (FAST_SIM=1): an SPI responder plus a timing/result model
// derived from the tick schedule, checking launch cycles, commands and result registers.
module tb_a2d_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done = 1'b0;
  logic [15:0] resp = 16'h0000;
  logic        snd;
  logic [15:0] cmd;
  logic [11:0] batt;
  logic [11:0] curr;
  logic [11:0] brake;
  logic [11:0] torque;
  logic        cnv_cmplt;

  a2d_scheduler #(.FAST_SIM(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .resp      (resp),
    .snd       (snd),
    .cmd       (cmd),
    .batt      (batt),
    .curr      (curr),
    .brake     (brake),
    .torque    (torque),
    .cnv_cmplt (cnv_cmplt)
  );

  always #5 clk = ~clk;

  // Number of clock edges since reset released; equals the period counter value.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int          ch_tab [4] = '{0, 1, 3, 4};
  int          m_idx   = 0;
  int          m_lprev = 1;
  int          m_ready = 0;
  logic [11:0] m_res [4] = '{12'h000, 12'h000, 12'h000, 12'h000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks happen in cycles 255 + 256n. A launch at L consumes the pending request,
  // so the next launch needs a tick at or after L-1 and must follow the previous return to idle.
  function automatic int next_launch();
    int base;
    int c;
    base = m_lprev - 1;
    if (base <= 255) c = 255;
    else             c = 255 + 256 * ((base - 255 + 255) / 256);
    return ((m_ready + 1) > (c + 2)) ? (m_ready + 1) : (c + 2);
  endfunction

  task automatic model_reset();
    m_idx   = 0;
    m_lprev = 1;
    m_ready = 0;
    for (int i = 0; i < 4; i++) m_res[i] = 12'h000;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_batt"},   {20'h0, batt},   {20'h0, m_res[0]});
    chk({tag, "_curr"},   {20'h0, curr},   {20'h0, m_res[1]});
    chk({tag, "_brake"},  {20'h0, brake},  {20'h0, m_res[2]});
    chk({tag, "_torque"}, {20'h0, torque}, {20'h0, m_res[3]});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_snd"}, {31'h0, snd}, 32'h0);
    chk({tag, "_cmd"}, {16'h0, cmd}, 32'h0);
    chk({tag, "_cnv"}, {31'h0, cnv_cmplt}, 32'h0);
    chk_outputs(tag);
  endtask

  task automatic wait_snd(output int t);
    t = 0;
    while (!snd && t < 3000) begin
      @(negedge clk);
      t++;
    end
  endtask

  // One command/read pair. d: SPI latency in clocks; coinc: also drive a done in the
  // snd cycles (must be ignored); rst_read: reset the DUT while it waits in READ.
  task automatic do_pair(input int d, input logic [11:0] val, input bit coinc, input bit rst_read);
    int  L;
    int  t;
    int  exp_cmd;
    bit  bad;
    L       = next_launch();
    exp_cmd = ch_tab[m_idx] << 11;
    bad     = 1'b0;
    wait_snd(t);
    chk("launch_cyc", cyc, L);
    chk("cmd_pair", {16'h0, cmd}, exp_cmd);
    L = cyc;
    if (coinc) begin
      done = 1'b1;
      resp = 16'hFABC;
    end
    @(negedge clk);
    done = 1'b0;
    while (cyc < L + d) begin
      if (snd || cnv_cmplt) bad = 1'b1;
      @(negedge clk);
    end
    done = 1'b1;
    resp = 16'($urandom_range(0, 65535));
    @(negedge clk);
    done = 1'b0;
    wait_snd(t);
    chk("read_snd_cyc", cyc, L + d + 2);
    chk("cmd_read", {16'h0, cmd}, exp_cmd);
    if (rst_read) begin
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      chk_reset_state("rst_in_read");
      rst = 1'b0;
      while (cyc < 10) @(negedge clk);
      done = 1'b1;
      resp = 16'hF777;
      @(negedge clk);
      done = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (snd || cnv_cmplt) bad = 1'b1;
      end
      chk("late_done_ignored", {31'h0, bad}, 32'h0);
      chk_outputs("after_late_done");
    end else begin
      if (coinc) begin
        done = 1'b1;
        resp = 16'hF000 | {4'h0, ~val};
      end
      @(negedge clk);
      done = 1'b0;
      while (cyc < L + 2 * d + 2) begin
        if (snd || cnv_cmplt) bad = 1'b1;
        @(negedge clk);
      end
      done = 1'b1;
      resp = 16'hF000 | {4'h0, val};
      @(negedge clk);
      done = 1'b0;
      m_res[m_idx] = val;
      chk("cnv_cmplt_hi", {31'h0, cnv_cmplt}, 32'h1);
      chk("cnv_cyc", cyc, L + 2 * d + 3);
      chk_outputs("result");
      chk("quiet_while_busy", {31'h0, bad}, 32'h0);
      m_lprev = L;
      m_ready = cyc;
      m_idx   = (m_idx + 1) % 4;
      @(negedge clk);
      chk("cnv_cmplt_lo", {31'h0, cnv_cmplt}, 32'h0);
      $display("pair ch=%0d d=%0d val=%03h launch=%0d done_cyc=%0d", ch_tab[(m_idx + 3) % 4], d, val, L, m_ready);
    end
  endtask

  task automatic spurious_idle_done();
    bit bad;
    bad  = 1'b0;
    done = 1'b1;
    resp = 16'hF5A5;
    @(negedge clk);
    done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (snd || cnv_cmplt) bad = 1'b1;
    end
    chk("idle_done_ignored", {31'h0, bad}, 32'h0);
    chk_outputs("idle_done");
    $display("spurious done in IDLE at cycle %0d", cyc);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    do_pair(20, 12'h3FF, 1'b0, 1'b0);
    do_pair(20, 12'h222, 1'b0, 1'b0);
    do_pair(20, 12'h333, 1'b0, 1'b0);
    do_pair(20, 12'h444, 1'b0, 1'b0);
    do_pair(20, 12'h111, 1'b0, 1'b0);

    do_pair(600, 12'($urandom_range(0, 4095)), 1'b0, 1'b0);
    do_pair(20, 12'($urandom_range(0, 4095)), 1'b0, 1'b0);
    do_pair(20, 12'($urandom_range(0, 4095)), 1'b0, 1'b0);

    spurious_idle_done();
    do_pair(20, 12'($urandom_range(0, 4095)), 1'b1, 1'b0);

    do_pair(20, 12'($urandom_range(0, 4095)), 1'b0, 1'b1);
    do_pair(20, 12'($urandom_range(0, 4095)), 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      do_pair(int'($urandom_range(3, 200)), 12'($urandom_range(0, 4095)),
              1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
